sram_like_arbiter: RTL and testbench
====================================

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 The block SHALL have no parameters; address and data widths are fixed at 32 bits.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock, rising-edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 i_req  input  1  instruction-side request (read-only master).
REQ-006 i_addr  input  32  instruction address.
REQ-007 i_addr_ok  output  1  instruction address accepted.
REQ-008 i_data_ok  output  1  instruction read data valid.
REQ-009 i_rdata  output  32  instruction read data.
REQ-010 d_req  input  1  data-side request.
REQ-011 d_wr  input  1  data-side write enable (1=write).
REQ-012 d_size  input  2  data-side size: 0 byte, 1 half, 2 word.
REQ-013 d_addr  input  32  data-side address.
REQ-014 d_wdata  input  32  data-side write data.
REQ-015 d_addr_ok  output  1  data-side address accepted.
REQ-016 d_data_ok  output  1  data-side transfer complete.
REQ-017 d_rdata  output  32  data-side read data.
REQ-018 m_req  output  1  shared bus request.
REQ-019 m_wr, m_size, m_addr, m_wdata  output  1/2/32/32  shared bus command fields.
REQ-020 m_addr_ok, m_data_ok  input  1/1  shared bus handshakes.
REQ-021 m_rdata  input  32  shared bus read data.

Function
REQ-022 The FSM SHALL have states IDLE, ADDR (request issued, awaiting m_addr_ok) and DATA (address accepted, awaiting m_data_ok), plus a 1-bit owner register (0=inst, 1=data).
REQ-023 In IDLE with any request pending, the arbiter SHALL pick a winner combinationally, drive m_req=1 in the same cycle and mux the winner's fields onto m_*; zero added latency.
REQ-024 Instruction requests SHALL drive m_wr=0, m_size=2'b10 and m_wdata=0.
REQ-025 IDLE transitions: no m_addr_ok -> ADDR; m_addr_ok without m_data_ok -> DATA; m_addr_ok with m_data_ok -> IDLE. Owner is latched on every exit from IDLE.
REQ-026 In ADDR, m_req SHALL stay 1 with fields muxed from the latched owner; the grant SHALL NOT change until m_addr_ok. Exit conditions match REQ-025.
REQ-027 In DATA, m_req SHALL be 0 (one outstanding transaction); m_data_ok -> IDLE. No new request is issued in the m_data_ok cycle.
REQ-028 x_addr_ok and x_data_ok SHALL equal m_addr_ok and m_data_ok gated to the current owner (winner in IDLE); the non-owner always sees 0.
REQ-029 i_rdata and d_rdata SHALL both equal m_rdata; they are valid only when the matching data_ok=1.
REQ-030 m_data_ok in IDLE with no request pending, and m_addr_ok in DATA, SHALL be ignored.
REQ-031 Default priority SHALL be fixed: data side wins when both requesters are pending.

Reset
REQ-032 While resetn=0 the block SHALL hold state=IDLE, owner=1 and last_served=1, and force m_req, i_addr_ok, i_data_ok, d_addr_ok and d_data_ok to 0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction; the block does not replay it after reset and the slave reset is responsible for the bus side.

Configuration
REQ-034 With ARB_ROUND_ROBIN_EN defined, the arbiter SHALL use a last_served register updated on each m_addr_ok; the side not last served wins ties. Reset value 1 means inst wins the first tie.
REQ-035 Without ARB_ROUND_ROBIN_EN, the last_served register SHALL NOT exist and fixed data priority applies.

Verification
REQ-036 i_req=1, d_req=0, m_addr_ok and m_data_ok one cycle later -> m_req=1 in the request cycle, i_addr_ok=1, then i_data_ok=1 with i_rdata=m_rdata=0x1234_5678.
REQ-037 i_req=d_req=1 in the same cycle, macro off -> m_addr=d_addr, d_addr_ok=1, i_addr_ok=0; inst is granted only after d_data_ok.
REQ-038 Same stimulus repeated twice, macro on -> first grant inst, second grant data, third grant inst.
REQ-039 m_addr_ok held low for 3 cycles while d_req is raised during the inst wait -> m_addr stays i_addr with no grant switch; exactly one i_addr_ok pulse.
REQ-040 m_addr_ok and m_data_ok both 1 in the IDLE request cycle -> single-cycle completion, state stays IDLE, next request issued the following cycle.
REQ-041 resetn pulled low while in DATA -> all handshake outputs 0 immediately; after release, state is IDLE and a stale m_data_ok is ignored.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// ============================================================================
// Module   : sram_like_arbiter
// Brief    : Two-master (inst/data) to one-slave SRAM-like bus arbiter, one
//            outstanding transaction. Define ARB_ROUND_ROBIN_EN for tie
//            alternation; default build gives the data side fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_like_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;

    logic   w_any_req;
    logic   w_winner;
    logic   w_owner;
    logic   w_issue;
    logic   w_addr_hs;
    logic   w_data_hs;

    assign w_any_req = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_served_q, last_served_d;

    // On a tie the side that was not served last wins; a lone requester always wins.
    always_comb begin
        w_winner = d_req;
        if (i_req && d_req) begin
            w_winner = ~last_served_q;
        end
    end

    assign last_served_d = w_addr_hs ? w_owner : last_served_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_served_q <= 1'b1;
        end else begin
            last_served_q <= last_served_d;
        end
    end
`else
    assign w_winner = d_req;
`endif

    assign w_owner = (state_q == IDLE) ? w_winner : owner_q;

    // resetn gating keeps every handshake quiet while reset is held, even with requests pending.
    assign w_issue   = resetn && (((state_q == IDLE) && w_any_req) || (state_q == ADDR));
    assign w_addr_hs = w_issue && m_addr_ok;
    assign w_data_hs = resetn && m_data_ok && ((state_q == DATA) || w_addr_hs);

    assign m_req   = w_issue;
    assign m_wr    = w_owner & d_wr;
    assign m_size  = w_owner ? d_size  : 2'b10;
    assign m_addr  = w_owner ? d_addr  : i_addr;
    assign m_wdata = w_owner ? d_wdata : 32'd0;

    assign i_addr_ok = w_addr_hs & ~w_owner;
    assign d_addr_ok = w_addr_hs &  w_owner;
    assign i_data_ok = w_data_hs & ~w_owner;
    assign d_data_ok = w_data_hs &  w_owner;
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (w_any_req) begin
                    owner_d = w_winner;
                    if (!m_addr_ok) begin
                        state_d = ADDR;
                    end else if (!m_data_ok) begin
                        state_d = DATA;
                    end
                end
            end
            ADDR: begin
                if (m_addr_ok) begin
                    state_d = m_data_ok ? IDLE : DATA;
                end
            end
            DATA: begin
                if (m_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
// ============================================================================
// Module   : tb_sram_like_arbiter
// Brief    : Scoreboard bench for sram_like_arbiter: directed stimulus pushes
//            expected handshakes, a monitor pops them as the DUT raises them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_like_arbiter;

    logic        clk;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_rdata;
    logic        d_req, d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] d_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    sram_like_arbiter u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_addr_ok (i_addr_ok),
        .i_data_ok (i_data_ok),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_size    (d_size),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_addr_ok (d_addr_ok),
        .d_data_ok (d_data_ok),
        .d_rdata   (d_rdata),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_size    (m_size),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_data;
        logic        side;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [2:0] TIE_SIDES = 3'b010;
`else
    localparam logic [2:0] TIE_SIDES = 3'b111;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_addr(input logic side, input logic [31:0] a);
        sb.push_back('{is_data: 1'b0, side: side, val: a});
    endtask

    task automatic exp_data(input logic side, input logic [31:0] d);
        sb.push_back('{is_data: 1'b1, side: side, val: d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handle(input logic is_data, input logic side);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_handshake: got data=%0b side=%0b expected none at %0t",
                     is_data, side, $time);
        end else begin
            e = sb.pop_front();
            check("handshake_kind_side", {30'd0, is_data, side}, {30'd0, e.is_data, e.side});
            if (!is_data) begin
                check("granted_addr", m_addr, e.val);
            end else begin
                check("read_data", side ? d_rdata : i_rdata, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (i_addr_ok) handle(1'b0, 1'b0);
        if (d_addr_ok) handle(1'b0, 1'b1);
        if (i_data_ok) handle(1'b1, 1'b0);
        if (d_data_ok) handle(1'b1, 1'b1);
    end

    initial begin
        resetn = 1'b0; i_req = 1'b1; i_addr = 32'h0; d_req = 1'b0; d_wr = 1'b0;
        d_size = 2'd2; d_addr = 32'h0; d_wdata = 32'h0;
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h0;

        // Reset held with a request and bus handshakes present
        @(negedge clk);
        check("rst_m_req", {31'd0, m_req}, 32'd0);
        check("rst_handshakes", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'd0);
        tick();

        // Three back-to-back single-cycle ties
        resetn = 1'b1;
        i_req = 1'b1; i_addr = 32'h0000_0200;
        d_req = 1'b1; d_addr = 32'h0000_0300;
        for (int k = 0; k < 3; k++) begin
            m_rdata = 32'hD00D_0000 + k;
            exp_addr(TIE_SIDES[2-k], TIE_SIDES[2-k] ? 32'h0000_0300 : 32'h0000_0200);
            exp_data(TIE_SIDES[2-k], m_rdata);
            @(negedge clk);
            check("tie_m_req", {31'd0, m_req}, 32'd1);
            tick();
        end

        // Two-cycle tie: data wins, inst waits for d_data_ok
        m_data_ok = 1'b0;
        exp_addr(1'b1, 32'h0000_0300);
        tick();
        d_req = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hAAAA_5555;
        exp_data(1'b1, 32'hAAAA_5555);
        @(negedge clk);
        check("data_phase_m_req", {31'd0, m_req}, 32'd0);
        check("data_phase_i_addr_ok", {31'd0, i_addr_ok}, 32'd0);
        tick();
        m_rdata = 32'h0BAD_F00D;
        exp_addr(1'b0, 32'h0000_0200);
        exp_data(1'b0, 32'h0BAD_F00D);
        tick();

        // Lone inst read: address then data one cycle later
        i_addr = 32'h0000_0100; m_data_ok = 1'b0;
        exp_addr(1'b0, 32'h0000_0100);
        @(negedge clk);
        check("inst_m_size", {30'd0, m_size}, 32'd2);
        check("inst_m_wdata", m_wdata, 32'd0);
        tick();
        i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h1234_5678;
        exp_data(1'b0, 32'h1234_5678);
        tick();

        // Grant held through a slow m_addr_ok while data side arrives
        i_req = 1'b1; i_addr = 32'h0000_0500; m_data_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_m_addr", m_addr, 32'h0000_0500);
            check("hold_m_wr", {31'd0, m_wr}, 32'd0);
            tick();
            d_req = 1'b1; d_wr = 1'b1; d_size = 2'd0;
            d_addr = 32'h0000_0404; d_wdata = 32'hCAFE_BABE;
        end
        m_addr_ok = 1'b1;
        exp_addr(1'b0, 32'h0000_0500);
        tick();
        i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h55AA_33CC;
        exp_data(1'b0, 32'h55AA_33CC);
        tick();
        m_addr_ok = 1'b1; m_data_ok = 1'b0;
        exp_addr(1'b1, 32'h0000_0404);
        @(negedge clk);
        check("write_m_wr", {31'd0, m_wr}, 32'd1);
        check("write_m_size", {30'd0, m_size}, 32'd0);
        check("write_m_wdata", m_wdata, 32'hCAFE_BABE);
        tick();

        // Reset during DATA, then a stale m_data_ok after release
        d_req = 1'b0; i_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1;
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_m_req", {31'd0, m_req}, 32'd0);
        check("midrst_handshakes", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'd0);
        tick();
        tick();
        resetn = 1'b1; i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
        @(negedge clk);
        check("stale_m_req", {31'd0, m_req}, 32'd0);
        check("stale_handshakes", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'd0);
        tick();
        i_req = 1'b1; i_addr = 32'h0000_0600; m_addr_ok = 1'b1; m_rdata = 32'hFEED_FACE;
        exp_addr(1'b0, 32'h0000_0600);
        exp_data(1'b0, 32'hFEED_FACE);
        tick();
        i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
        tick();
        tick();

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
